mem_port_arbiter: RTL and testbench

Shares the pipelined CPU's single-port unified memory between the instruction-fetch (IF) stage and the data-access (MEM) stage. One access per cycle is issued to memory. Data requests have priority, and a streak counter prevents fetch starvation. The block generates per-requester stall signals consumed by the hazard logic, and returns read data one cycle after grant.

---
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and data access.
// Data wins ties until its streak limit is reached; responses return one cycle after grant.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_D_STREAK = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_stall,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_stall,
  output logic                  d_valid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [15:0]           conflict_cnt
);

  // owner state | meaning
  // OWN_NONE    | no access issued last cycle, no response due
  // OWN_IF      | fetch issued last cycle, mem_rdata belongs to IF
  // OWN_D_RD    | load issued last cycle, mem_rdata belongs to data port
  // OWN_D_WR    | store issued last cycle, acknowledge data port
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D_RD, OWN_D_WR} owner_t;

  localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

  owner_t      owner_q, owner_d;
  logic [3:0]  streak_q, streak_d;
  logic [15:0] conflict_q, conflict_d;
  logic        hold_q;
  logic        grant_en;
  logic        streak_full;
  logic        pick_if;
  logic        pick_d;

  // hold_q blocks grants for the first cycle after reset so that cycle stays quiet
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q    <= OWN_NONE;
      streak_q   <= 4'd0;
      conflict_q <= 16'd0;
      hold_q     <= 1'b1;
    end else begin
      owner_q    <= owner_d;
      streak_q   <= streak_d;
      conflict_q <= conflict_d;
      hold_q     <= 1'b0;
    end
  end

  always_comb begin
    grant_en    = !reset && !hold_q;
    streak_full = (streak_q == MAX_S);
    pick_if     = if_req && (!d_req || streak_full);
    pick_d      = d_req && !pick_if;
    if_gnt      = grant_en && pick_if;
    d_gnt       = grant_en && pick_d;
    if_stall    = if_req && !if_gnt;
    d_stall     = d_req && !d_gnt;
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (d_gnt) begin
      owner_d = d_we ? OWN_D_WR : OWN_D_RD;
    end

    streak_d = streak_q;
    if (!if_req || if_gnt) begin
      streak_d = 4'd0;
    end else if (d_gnt && !streak_full) begin
      streak_d = streak_q + 4'd1;
    end

    conflict_d = conflict_q;
    if (if_req && d_req && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_comb begin
    mem_en    = if_gnt || d_gnt;
    mem_we    = d_gnt && d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_addr = if_addr;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end

    if_valid = 1'b0;
    if_rdata = '0;
    d_valid  = 1'b0;
    d_rdata  = '0;
    if (!reset) begin
      case (owner_q)
        OWN_IF: begin
          if_valid = 1'b1;
          if_rdata = mem_rdata;
        end
        OWN_D_RD: begin
          d_valid = 1'b1;
          d_rdata = mem_rdata;
        end
        OWN_D_WR: d_valid = 1'b1;
        default: ;
      endcase
    end

    conflict_cnt = reset ? 16'd0 : conflict_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: reference arbitration model plus response scoreboard,
// directed scenarios, constrained random traffic and counter saturation.
module tb_mem_port_arbiter;

  localparam logic [3:0] MAXS = 4'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_stall, if_valid, d_gnt, d_stall, d_valid;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic [15:0] conflict_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_D_STREAK(3)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_stall(if_stall),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_stall(d_stall), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    logic [11:0] lo;
    lo = i[11:0];
    return (i == 16) ? 32'h2008_0001 : {16'hC0DE, 4'h0, lo};
  endfunction

  // Environment memory: registered read, one cycle latency
  logic [31:0] ram [4096];
  bit ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 4096; i++) ram[i] = init_word(i);
      ram_ready = 1'b1;
    end
    if (mem_en) begin
      if (mem_we) ram[mem_addr[13:2]] = mem_wdata;
      else        mem_rdata <= ram[mem_addr[13:2]];
    end
  end

  typedef struct packed {
    logic        iv;
    logic        dv;
    logic [31:0] ir;
    logic [31:0] dr;
  } resp_t;

  resp_t       sb[$];
  resp_t       exp_r, nxt;
  logic [31:0] ref_mem [4096];
  bit          ref_ready = 1'b0;
  logic        m_hold = 1'b1;
  logic [3:0]  m_streak = 4'd0;
  logic [15:0] m_conf = 16'd0;
  logic        m_en, e_if, e_d;

  // Monitor: model the arbiter each cycle, check outputs, queue next-cycle response
  always @(negedge clk) begin
    if (!ref_ready) begin
      for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
      ref_ready = 1'b1;
    end
    exp_r = (sb.size() > 0) ? sb.pop_front() : '0;
    if (reset) exp_r = '0;
    chk("if_valid", if_valid, exp_r.iv);
    chk("if_rdata", if_rdata, exp_r.ir);
    chk("d_valid",  d_valid,  exp_r.dv);
    chk("d_rdata",  d_rdata,  exp_r.dr);

    m_en = !reset && !m_hold;
    e_if = m_en && if_req && (!d_req || (m_streak == MAXS));
    e_d  = m_en && d_req && !e_if;
    chk("if_gnt",    if_gnt,    e_if);
    chk("d_gnt",     d_gnt,     e_d);
    chk("if_stall",  if_stall,  if_req && !e_if);
    chk("d_stall",   d_stall,   d_req && !e_d);
    chk("mem_en",    mem_en,    e_if || e_d);
    chk("mem_we",    mem_we,    e_d && d_we);
    chk("mem_addr",  mem_addr,  e_if ? if_addr : (e_d ? d_addr : 32'd0));
    chk("mem_wdata", mem_wdata, e_d ? d_wdata : 32'd0);
    chk("conflict",  conflict_cnt, reset ? 16'd0 : m_conf);

    nxt = '0;
    if (e_if) begin
      nxt.iv = 1'b1;
      nxt.ir = ref_mem[if_addr[13:2]];
    end else if (e_d) begin
      nxt.dv = 1'b1;
      if (d_we) ref_mem[d_addr[13:2]] = d_wdata;
      else      nxt.dr = ref_mem[d_addr[13:2]];
    end
    sb.push_back(nxt);

    if (reset) begin
      m_streak = 4'd0;
      m_conf   = 16'd0;
    end else begin
      if (!if_req || e_if)                m_streak = 4'd0;
      else if (e_d && m_streak < MAXS)    m_streak = m_streak + 4'd1;
      if (if_req && d_req && m_conf != 16'hFFFF) m_conf = m_conf + 16'd1;
    end
    m_hold = reset;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_traffic(input int n);
    logic gi, gd;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      gi = if_gnt;
      gd = d_gnt;
      cyc();
      if (!if_req || gi) begin
        if_req  = 1'($urandom_range(0, 1));
        if_addr = 32'h40 + 32'($urandom_range(0, 15)) * 4;
      end
      if (!d_req || gd) begin
        d_req   = 1'($urandom_range(0, 1));
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
        d_wdata = $urandom;
      end
    end
  endtask

  logic [7:0] pat, spat;

  initial begin
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cyc();

    // single fetch
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk) chk("fetch_gnt", if_gnt, 1);
    cyc();
    if_req = 1'b0;
    @(negedge clk);
    chk("fetch_valid",  if_valid, 1);
    chk("fetch_rdata",  if_rdata, 32'h2008_0001);
    chk("fetch_dvalid", d_valid, 0);
    cyc();

    // store then load to the same address
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk) chk("store_mem_we", mem_we, 1);
    cyc();
    d_we = 1'b0;
    @(negedge clk);
    chk("load_mem_we", mem_we, 0);
    chk("store_ack",   d_valid, 1);
    chk("store_rdata", d_rdata, 0);
    cyc();
    d_req = 1'b0;
    @(negedge clk);
    chk("load_valid", d_valid, 1);
    chk("load_rdata", d_rdata, 32'hDEAD_BEEF);
    cyc();

    // contention for 8 cycles
    if_req = 1'b1; d_req = 1'b1; if_addr = 32'h40; d_addr = 32'h1000;
    pat = '0; spat = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      pat  = {pat[6:0], if_gnt};
      spat = {spat[6:0], if_stall};
      cyc();
    end
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("contend_if_gnt",   pat,  8'b0001_0001);
    chk("contend_if_stall", spat, 8'b1110_1110);
    chk("contend_conflict", conflict_cnt, 16'd8);
    cyc();

    // streak restarts when if_req drops for a cycle
    pat = '0;
    for (int k = 0; k < 7; k++) begin
      if_req = (k != 2);
      d_req  = 1'b1;
      @(negedge clk);
      pat = {pat[6:0], if_gnt};
      cyc();
    end
    if_req = 1'b0; d_req = 1'b0;
    chk("streak_clear", pat[6:0], 7'b000_0001);
    cyc();

    rand_traffic(300);
    if_req = 1'b0; d_req = 1'b0;
    cyc();
    cyc();

    // reset right after a load grant: the response must be dropped
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1004;
    @(negedge clk) chk("rst_load_gnt", d_gnt, 1);
    cyc();
    reset = 1'b1; d_req = 1'b0;
    @(negedge clk);
    chk("rst_d_valid",  d_valid, 0);
    chk("rst_conflict", conflict_cnt, 0);
    cyc();
    reset = 1'b0; if_req = 1'b1; if_addr = 32'h44;
    @(negedge clk);
    chk("post_rst_d_valid", d_valid, 0);
    chk("post_rst_if_gnt",  if_gnt, 0);
    chk("post_rst_stall",   if_stall, 1);
    chk("post_rst_mem_en",  mem_en, 0);
    cyc();
    @(negedge clk) chk("post_rst_grant", if_gnt, 1);
    cyc();
    if_req = 1'b0;
    cyc();

    // conflict counter saturation
    if_req = 1'b1; d_req = 1'b1; if_addr = 32'h48; d_addr = 32'h1008; d_we = 1'b0;
    repeat (65540) cyc();
    @(negedge clk) chk("sat_conflict", conflict_cnt, 16'hFFFF);
    repeat (3) cyc();
    @(negedge clk) chk("sat_hold", conflict_cnt, 16'hFFFF);
    cyc();
    if_req = 1'b0; d_req = 1'b0;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
